// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART byte transmitter between N byte-stream requesters.
//   A granted requester owns the transmitter for a whole packet, which ends
//   at its `last` byte. Grants rotate round-robin between packets. One
//   registered holding byte (tx_word/tx_valid) sits between the owner and
//   the transmitter handshake.
//
// Parameters
//   N        number of requesters (2..8)
//   TIMEOUT  idle cycles tolerated from an owner before forced release
//            (only used when UART_TX_ARB_TIMEOUT_EN is defined)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   req_valid    [N]    requester i presents a byte
//   req_data     [8N]   byte of requester i in bits [8i+7:8i]
//   req_last     [N]    byte of requester i ends its packet
//   req_ready    [N]    one-cycle accept pulse; the byte is taken that cycle
//   grant        [N]    one-hot owner, all-zero when idle
//   tx_word      [8]    byte to the transmitter (holds value after transfer)
//   tx_valid            tx_word is valid
//   tx_ready            transmitter takes tx_word when tx_valid && tx_ready
//   pkt_count    [16]   completed packets since reset, wrapping
//   timeout_err         one-cycle pulse on a forced release
//
// Configuration
//   UART_TX_ARB_TIMEOUT_EN  enables the stalled-owner release counter;
//                           without it timeout_err is constant 0.
//
// All outputs are registered.

module uart_tx_arbiter #(
  parameter int unsigned N       = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   grant,
  output logic [7:0]     tx_word,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [15:0]    pkt_count,
  output logic           timeout_err
);

  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  generate
    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("uart_tx_arbiter: N must be 2..8 and TIMEOUT at least 1");
    end
  endgenerate

  // OWN: holding empty or holding a non-last byte; DRAIN: holding the last byte.
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   own_q, own_d, own_nxt;
  logic [PW-1:0]   win, cand;
  logic            found;
  logic [N-1:0]    grant_d, req_ready_d;
  logic [7:0]      tx_word_d, own_data;
  logic            tx_valid_d, timeout_d;
  logic [15:0]     pkt_count_d;
  logic            xfer, own_valid, own_last;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign xfer      = tx_valid & tx_ready;
  assign own_valid = req_valid[own_q];
  assign own_last  = req_last[own_q];
  assign own_data  = req_data[{own_q, 3'b000} +: 8];
  assign own_nxt   = (own_q == PW'(N - 1)) ? '0 : own_q + 1'b1;

  // Round-robin search starting at ptr_q, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = PW'((32'(ptr_q) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    grant_d     = grant;
    req_ready_d = '0;
    tx_word_d   = tx_word;
    tx_valid_d  = tx_valid;
    pkt_count_d = pkt_count;
    timeout_d   = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = OWN;
          own_d       = win;
          grant_d     = ONE << win;
          req_ready_d = ONE << win;
        end
      end
      OWN: begin
        if (!tx_valid) begin
          // req_ready is registered: a pulse issued last cycle means the
          // byte is taken now, provided the requester still holds valid.
          if (req_ready[own_q] && own_valid) begin
            tx_word_d  = own_data;
            tx_valid_d = 1'b1;
            state_d    = own_last ? DRAIN : OWN;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end else begin
            if (!req_ready[own_q])
              req_ready_d = own_valid ? grant : '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (!own_valid) begin
              if (cnt_q == CW'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                ptr_d     = own_nxt;
                grant_d   = '0;
                state_d   = IDLE;
                cnt_d     = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end
`endif
          end
        end else if (xfer) begin
          // Holding is empty next cycle, so the accept pulse can go out then.
          tx_valid_d  = 1'b0;
          req_ready_d = own_valid ? grant : '0;
        end
      end
      DRAIN: begin
        if (xfer) begin
          tx_valid_d  = 1'b0;
          pkt_count_d = pkt_count + 16'd1;
          ptr_d       = own_nxt;
          grant_d     = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      grant       <= '0;
      req_ready   <= '0;
      tx_word     <= '0;
      tx_valid    <= 1'b0;
      pkt_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      grant       <= grant_d;
      req_ready   <= req_ready_d;
      tx_word     <= tx_word_d;
      tx_valid    <= tx_valid_d;
      pkt_count   <= pkt_count_d;
      timeout_err <= timeout_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N=2 and TIMEOUT=16.
// A negedge environment process models both requesters (byte queues with
// valid held until accepted) and the transmitter (tx_ready after a
// programmable delay) and logs every transfer with its owner.

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic [7:0]  tx_word;
  logic        tx_valid, tx_ready;
  logic [15:0] pkt_count;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .pkt_count(pkt_count), .timeout_err(timeout_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic [15:0] log_q[$];
  int          tx_delay   = 0;
  bit          idle_ready = 1'b0;
  bit          inv_en     = 1'b0;
  int          vcnt       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check("log_len", 32'(log_q.size()), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_grant"},     32'(grant), 32'd0);
    check({tag, "_tx_word"},   32'(tx_word), 32'd0);
    check({tag, "_tx_valid"},  32'(tx_valid), 32'd0);
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    check({tag, "_timeout"},   32'(timeout_err), 32'd0);
  endtask

  // Environment: drives inputs for the current cycle and records handshakes.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (inv_en) begin
        check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        check("ready_only_owner", 32'(req_ready & ~grant), 32'd0);
      end
      vcnt     = tx_valid ? vcnt + 1 : 0;
      tx_ready = tx_valid ? (tx_delay >= 0 && vcnt > tx_delay) : idle_ready;
      req_valid[0] = (src0.size() > 0);
      if (src0.size() > 0) {req_last[0], req_data[7:0]} = src0[0];
      else                 {req_last[0], req_data[7:0]} = '0;
      req_valid[1] = (src1.size() > 0);
      if (src1.size() > 0) {req_last[1], req_data[15:8]} = src1[0];
      else                 {req_last[1], req_data[15:8]} = '0;
      if (tx_valid && tx_ready) log_q.push_back({6'b0, grant, tx_word});
      if (req_valid[0] && req_ready[0]) void'(src0.pop_front());
      if (req_valid[1] && req_ready[1]) void'(src1.pop_front());
    end
  end

  initial begin
    string hello;
    int    k;
    logic [15:0] exp2 [6];
    exp2 = '{16'h0110, 16'h0111, 16'h0230, 16'h0231, 16'h0120, 16'h0121};

    // Reset values
    rst = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    inv_en = 1'b1;

    // Single requester "Hi\n", tx_ready three cycles after tx_valid
    tx_delay = 3;
    src0.push_back(9'h048);
    src0.push_back(9'h069);
    src0.push_back(9'h10A);
    rst = 1'b1;
    step();                                    // arbitration result
    check("hi_c1_grant", 32'(grant), 32'd1);
    check("hi_c1_ready", 32'(req_ready), 32'd1);
    check("hi_c1_valid", 32'(tx_valid), 32'd0);
    step();
    check("hi_c2_valid", 32'(tx_valid), 32'd1);
    check("hi_c2_word",  32'(tx_word), 32'h48);
    check("hi_c2_ready", 32'(req_ready), 32'd0);
    repeat (3) step();
    check("hi_c5_valid", 32'(tx_valid), 32'd1);
    check("hi_c5_word",  32'(tx_word), 32'h48);
    step();
    check("hi_c6_valid", 32'(tx_valid), 32'd0);
    check("hi_c6_word",  32'(tx_word), 32'h48);
    check("hi_c6_ready", 32'(req_ready), 32'd1);
    repeat (9) step();
    check("hi_c15_grant", 32'(grant), 32'd1);
    check("hi_c15_word",  32'(tx_word), 32'h0A);
    check("hi_c15_pkt",   32'(pkt_count), 32'd0);
    step();
    check("hi_c16_grant", 32'(grant), 32'd0);
    check("hi_c16_pkt",   32'(pkt_count), 32'd1);
    check("hi_c16_valid", 32'(tx_valid), 32'd0);
    check("hi_c16_word",  32'(tx_word), 32'h0A);
    check("hi_log_len", 32'(log_q.size()), 32'd3);
    check("hi_log0", 32'(log_q[0]), 32'h0148);
    check("hi_log1", 32'(log_q[1]), 32'h0169);
    check("hi_log2", 32'(log_q[2]), 32'h010A);

    // Contention from reset, tx_ready also high while tx_valid is low
    log_q.delete();
    rst = 1'b0;
    step();
    rst = 1'b1;
    tx_delay   = 0;
    idle_ready = 1'b1;
    src0.push_back(9'h010); src0.push_back(9'h111);
    src0.push_back(9'h020); src0.push_back(9'h121);
    src1.push_back(9'h030); src1.push_back(9'h131);
    wait_log(6, 200);
    repeat (3) step();
    for (int i = 0; i < 6; i++) check($sformatf("rr_log%0d", i), 32'(log_q[i]), 32'(exp2[i]));
    check("rr_pkt",   32'(pkt_count), 32'd3);
    check("rr_grant", 32'(grant), 32'd0);

    // Backpressure: tx_ready low for 50 cycles with holding full
    log_q.delete();
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle_ready = 1'b0;
    tx_delay   = -1;
    src0.push_back(9'h055);
    src0.push_back(9'h1AA);
    k = 0;
    while (!tx_valid && k < 20) begin
      step();
      k++;
    end
    check("bp_start", 32'(tx_valid), 32'd1);
    repeat (50) begin
      step();
      check("bp_word",  32'(tx_word), 32'h55);
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    tx_delay = 0;
    wait_log(2, 50);
    check("bp_log0", 32'(log_q[0]), 32'h0155);
    check("bp_log1", 32'(log_q[1]), 32'h01AA);
    repeat (3) step();
    check("bp_pkt", 32'(pkt_count), 32'd1);

    // Reset after the 5th byte of "Hello world!\n"; ptr was 1 beforehand
    log_q.delete();
    hello = "Hello world!\n";
    for (int i = 0; i < hello.len(); i++)
      src0.push_back({(i == hello.len() - 1) ? 1'b1 : 1'b0, hello[i]});
    wait_log(5, 200);
    rst = 1'b0;
    step();
    check_reset_outputs("midrst");
    check("midrst_log_len", 32'(log_q.size()), 32'd5);
    rst = 1'b1;
    src0.delete();
    src0.push_back(9'h1A0);
    src0.push_back(9'h1A1);
    src1.push_back(9'h1B0);
    step();
    check("midrst_ptr_grant", 32'(grant), 32'd1);
    wait_log(8, 100);
    check("midrst_log4", 32'(log_q[4]), 32'h016F);
    check("midrst_log5", 32'(log_q[5]), 32'h01A0);
    check("midrst_log6", 32'(log_q[6]), 32'h02B0);
    check("midrst_log7", 32'(log_q[7]), 32'h01A1);
    repeat (3) step();
    check("midrst_pkt", 32'(pkt_count), 32'd3);

    // Requester 1 sends one non-last byte then stalls
    log_q.delete();
    src1.push_back(9'h0C3);
    step();
    check("stall_c1_grant", 32'(grant), 32'd2);
    check("stall_c1_ready", 32'(req_ready), 32'd2);
    step();
    check("stall_c2_valid", 32'(tx_valid), 32'd1);
    check("stall_c2_word",  32'(tx_word), 32'hC3);
    step();
    check("stall_c3_grant", 32'(grant), 32'd2);
    check("stall_c3_valid", 32'(tx_valid), 32'd0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (15) step();
    check("to_c18_err",   32'(timeout_err), 32'd0);
    check("to_c18_grant", 32'(grant), 32'd2);
    step();
    check("to_c19_err",   32'(timeout_err), 32'd1);
    check("to_c19_grant", 32'(grant), 32'd0);
    check("to_c19_pkt",   32'(pkt_count), 32'd3);
    step();
    check("to_c20_err", 32'(timeout_err), 32'd0);
    src0.push_back(9'h1D0);
    src1.push_back(9'h1E0);
    step();
    check("to_ptr_grant", 32'(grant), 32'd1);
    wait_log(3, 100);
    check("to_log1", 32'(log_q[1]), 32'h01D0);
    check("to_log2", 32'(log_q[2]), 32'h02E0);
`else
    repeat (10000) begin
      step();
      check("stall_grant", 32'(grant), 32'd2);
      check("stall_err",   32'(timeout_err), 32'd0);
    end
    check("stall_pkt", 32'(pkt_count), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
